// File: rtl/apb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// apb_arbiter_pkg
// Shared types and default constants for the two-requester APB arbiter.
//   apb_state_t : APB master phase (IDLE / SETUP / ACCESS)
//   req_idx_t   : requester index (0 or 1)
//   DEF_*       : default widths and access timeout
//   idx_to_onehot : requester index -> 2-bit one-hot vector
// ----------------------------------------------------------------------------
package apb_arbiter_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   typedef logic [0:0] req_idx_t;

   function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
      return (idx == 1'b1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/apb_arbiter_rr.sv
// ----------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way round-robin grant. Purely combinational.
// Ports:
//   valid    in  2  request valid per requester
//   last_gnt in  1  requester granted most recently
//   grant    out 2  one-hot grant (all zero when nothing is valid)
// ----------------------------------------------------------------------------
module apb_rr_arbiter
   import apb_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  req_idx_t   last_gnt,
   output logic [1:0] grant
);

   // A lone requester is simply granted; on a tie the one not served last wins.
   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/apb_arbiter.sv
// ----------------------------------------------------------------------------
// apb_arbiter
// Arbitrates two simple request/response ports onto a single APB master.
// One transfer is in flight at a time; a new request can be accepted in the
// same cycle the previous response is pulsed, giving a 3-cycle minimum
// spacing between transfers.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no PREADY for TIMEOUT cycles is
//   abandoned and answered with rsp_err=1. When undefined, there is no
//   counter, rsp_err is tied to 0 and ACCESS waits indefinitely.
//
// Ports:
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (2 bits each)
//   req_write             per-requester direction, 1 = write
//   req_addr/wdata/strb   per-requester payload, requester i in slice i
//   rsp_valid             one-cycle response pulse to the owning requester
//   rsp_rdata, rsp_err    response data (0 for writes) and error flag
//   PSEL..PSTRB           APB master outputs
//   PRDATA, PREADY        APB slave response
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transfer; req_ready offered to the round-robin winner
// SETUP  | payload registered, PSEL=1 PENABLE=0 for one cycle
// ACCESS | PSEL=1 PENABLE=1 until PREADY (or timeout when enabled)
// ----------------------------------------------------------------------------
module apb_arbiter
   import apb_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic                    PCLK,
   input  logic                    PRESET,

   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]     req_wdata,
   input  logic [2*DATA_W/8-1:0]   req_strb,

   output logic [1:0]              rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,

   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_W-1:0]       PADDR,
   output logic [DATA_W-1:0]       PWDATA,
   output logic [DATA_W/8-1:0]     PSTRB,
   input  logic [DATA_W-1:0]       PRDATA,
   input  logic                    PREADY
);

   localparam int STRB_W = DATA_W / 8;

   apb_state_t          state;
   apb_state_t          state_nxt;
   req_idx_t            last_gnt;
   req_idx_t            owner;
   req_idx_t            gnt_idx;
   logic [1:0]          grant;
   logic                handshake;
   logic                xfer_done;
   logic                xfer_timeout;

   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [STRB_W-1:0]   sel_strb;

   apb_rr_arbiter u_rr (
      .valid    (req_valid),
      .last_gnt (last_gnt),
      .grant    (grant)
   );

   assign gnt_idx   = grant[1];
   assign handshake = |(req_valid & req_ready);
   assign xfer_done = (state == ACCESS) && PREADY;

   always_comb begin
      sel_addr  = req_addr[ADDR_W-1:0];
      sel_wdata = req_wdata[DATA_W-1:0];
      sel_strb  = req_strb[STRB_W-1:0];
      if (gnt_idx == 1'b1) begin
         sel_addr  = req_addr[2*ADDR_W-1:ADDR_W];
         sel_wdata = req_wdata[2*DATA_W-1:DATA_W];
         sel_strb  = req_strb[2*STRB_W-1:STRB_W];
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (handshake) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (xfer_done || xfer_timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      case (state)
         IDLE:    req_ready = grant;
         SETUP:   PSEL      = 1'b1;
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------- payload capture
   // Captured once at the handshake so the APB payload stays stable for the
   // whole transfer regardless of what the requester does afterwards.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         last_gnt <= 1'b1;
         owner    <= 1'b0;
         PWRITE   <= 1'b0;
         PADDR    <= '0;
         PWDATA   <= '0;
         PSTRB    <= '0;
      end else if (handshake) begin
         last_gnt <= gnt_idx;
         owner    <= gnt_idx;
         PWRITE   <= req_write[gnt_idx];
         PADDR    <= sel_addr;
         PWDATA   <= sel_wdata;
         PSTRB    <= req_write[gnt_idx] ? sel_strb : '0;
      end
   end

   // --------------------------------------------------------------- response
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= (xfer_done || xfer_timeout) ? idx_to_onehot(owner) : 2'b00;
         rsp_rdata <= (xfer_done && !PWRITE) ? PRDATA : '0;
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] acc_cnt;

   // Loaded in SETUP so the first ACCESS cycle sees TIMEOUT-1; terminal count
   // (zero) marks the last ACCESS cycle allowed. PREADY in that cycle still wins.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         acc_cnt <= '0;
      end else if (state == SETUP) begin
         acc_cnt <= CNT_W'(TIMEOUT - 1);
      end else if ((state == ACCESS) && (acc_cnt != '0)) begin
         acc_cnt <= acc_cnt - CNT_W'(1);
      end
   end

   assign xfer_timeout = (state == ACCESS) && !PREADY && (acc_cnt == '0);

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rsp_err <= 1'b0;
      end else begin
         rsp_err <= xfer_timeout;
      end
   end
`else
   assign xfer_timeout = 1'b0;
   assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic [1:0]      req_valid, req_ready, req_write, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [2*SW-1:0] req_strb;
   logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
   logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY;
   logic [AW-1:0]   PADDR;
   logic [SW-1:0]   PSTRB;

   int total = 0;
   int bad   = 0;

   always #5 PCLK = ~PCLK;

   apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   typedef struct {
      int          who;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          waits;
      logic [31:0] prd;
      logic [3:0]  exp_strb;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } txn_t;

   vec_t vecs[4];
   txn_t q0[$];
   txn_t q1[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh(input int i);
      return (i == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic cyc_start();
      @(posedge PCLK);
      #1;
   endtask

   task automatic sample();
      @(negedge PCLK);
   endtask

   task automatic clear_inputs();
      req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
      req_strb = '0; PREADY = 1'b0; PRDATA = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      PRESET = 1'b1;
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;
   endtask

   task automatic present(input int who, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      req_write[who]          = w;
      req_addr[who*AW +: AW]  = a;
      req_wdata[who*DW +: DW] = d;
      req_strb[who*SW +: SW]  = s;
   endtask

   // random-phase model state
   int          last_g, owner, acc_cyc, rsp_at, rsp_owner, n_acc;
   logic        active, exp_pen, rsp_e, got, done;
   logic [31:0] rsp_data;
   txn_t        cur, t;
   logic [1:0]  vld, eg;
   int          order[4];

   initial begin
      PRESET = 1'b1;
      clear_inputs();

      vecs[0] = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 4'hF, 32'h0};
      vecs[1] = '{1, 1'b0, 32'h20,       32'h11111111, 4'hF, 3, 32'h12345678, 4'h0, 32'h12345678};
      vecs[2] = '{0, 1'b0, 32'h44,       32'h22222222, 4'h3, 1, 32'hCAFEF00D, 4'h0, 32'hCAFEF00D};
      vecs[3] = '{1, 1'b1, 32'hFFFFFFFC, 32'h01020304, 4'h5, 2, 32'hFFFFFFFF, 4'h5, 32'h0};
      order   = '{0, 1, 0, 1};

      // ---------------- reset state
      do_reset();
      sample();
      chk("rst_psel", PSEL, 0);       chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);   chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);   chk("rst_pstrb", PSTRB, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0); chk("rst_ready", req_ready, 0);

      // ---------------- table-driven single transfers
      for (int k = 0; k < 4; k++) begin
         cyc_start();
         clear_inputs();
         present(vecs[k].who, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].s);
         req_valid = oh(vecs[k].who);
         sample();
         chk("vec_ready", req_ready, oh(vecs[k].who));
         chk("vec_idle_psel", PSEL, 0);
         cyc_start();
         req_valid = 2'b00;
         sample();
         chk("vec_setup_sel", {PSEL, PENABLE}, 2'b10);
         chk("vec_setup_addr", PADDR, vecs[k].a);
         chk("vec_setup_write", PWRITE, vecs[k].w);
         chk("vec_setup_wdata", PWDATA, vecs[k].d);
         chk("vec_setup_strb", PSTRB, vecs[k].exp_strb);
         chk("vec_setup_ready", req_ready, 0);
         for (int j = 0; j <= vecs[k].waits; j++) begin
            cyc_start();
            PREADY = (j == vecs[k].waits);
            PRDATA = (j == vecs[k].waits) ? vecs[k].prd : (32'hBAD00000 + j);
            sample();
            chk("vec_access_sel", {PSEL, PENABLE}, 2'b11);
            chk("vec_access_addr", PADDR, vecs[k].a);
            chk("vec_access_strb", PSTRB, vecs[k].exp_strb);
            chk("vec_access_norsp", rsp_valid, 0);
         end
         cyc_start();
         PREADY = 1'b0; PRDATA = '0;
         sample();
         chk("vec_rsp_valid", rsp_valid, oh(vecs[k].who));
         chk("vec_rsp_rdata", rsp_rdata, vecs[k].exp_rd);
         chk("vec_rsp_err", rsp_err, 0);
         chk("vec_rsp_psel", PSEL, 0);
      end

      // ---------------- contention: back-to-back round robin
      do_reset();
      present(0, 1'b1, 32'h100, 32'hA0A0A0A0, 4'hF);
      present(1, 1'b0, 32'h200, 32'h0, 4'hF);
      req_valid = 2'b11; PREADY = 1'b1; PRDATA = 32'h55AA55AA;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) cyc_start();
         sample();
         if ((c % 3) == 0) chk("rr_ready", req_ready, oh(order[c/3]));
         else              chk("rr_ready_busy", req_ready, 0);
         if ((c % 3) == 1) chk("rr_paddr", PADDR, (order[c/3] == 1) ? 32'h200 : 32'h100);
         if (c >= 3 && (c % 3) == 0) begin
            chk("rr_rsp_overlap", rsp_valid, oh(order[c/3 - 1]));
            chk("rr_rsp_rdata", rsp_rdata, (order[c/3 - 1] == 1) ? 32'h55AA55AA : 32'h0);
         end
      end
      cyc_start();
      req_valid = 2'b00;
      sample();
      chk("rr_last_rsp", rsp_valid, oh(order[3]));
      chk("rr_last_rdata", rsp_rdata, 32'h55AA55AA);

      // ---------------- reset in the middle of ACCESS
      do_reset();
      present(0, 1'b1, 32'h30, 32'h77, 4'hF);
      req_valid = 2'b01;
      sample();
      cyc_start();
      req_valid = 2'b00;
      cyc_start();
      sample();
      chk("mid_rst_access", PENABLE, 1);
      #2 PRESET = 1'b1;
      #1;
      chk("mid_rst_psel", PSEL, 0);
      chk("mid_rst_penable", PENABLE, 0);
      chk("mid_rst_paddr", PADDR, 0);
      cyc_start();
      PRESET = 1'b0; PREADY = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sample();
         chk("mid_rst_norsp", rsp_valid, 0);
         chk("mid_rst_idle", PSEL, 0);
         cyc_start();
      end
      PREADY = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
      // ---------------- timeout with PREADY held low
      do_reset();
      present(0, 1'b0, 32'h40, 32'h0, 4'hF);
      req_valid = 2'b01; PRDATA = 32'hDEAD0001;
      sample();
      cyc_start();
      req_valid = 2'b00;
      n_acc = 0; got = 1'b0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         sample();
         if (PSEL && PENABLE) n_acc++;
         if (rsp_valid != 2'b00) begin
            got = 1'b1; done = 1'b1;
            chk("to_rsp_valid", rsp_valid, 2'b01);
            chk("to_rsp_err", rsp_err, 1);
            chk("to_rsp_rdata", rsp_rdata, 0);
            chk("to_psel", PSEL, 0);
         end
         cyc_start();
      end
      chk("to_access_cycles", n_acc, TO);
      chk("to_seen", got, 1);

      // ---------------- PREADY on the last allowed ACCESS cycle
      do_reset();
      present(1, 1'b0, 32'h48, 32'h0, 4'hF);
      req_valid = 2'b10; PRDATA = 32'h0BADCAFE;
      sample();
      cyc_start();
      req_valid = 2'b00;
      for (int k = 1; k <= TO; k++) begin
         cyc_start();
         PREADY = (k == TO);
      end
      cyc_start();
      PREADY = 1'b0;
      sample();
      chk("to_edge_rsp", rsp_valid, 2'b10);
      chk("to_edge_err", rsp_err, 0);
      chk("to_edge_rdata", rsp_rdata, 32'h0BADCAFE);
`else
      // ---------------- no timeout: ACCESS waits indefinitely
      do_reset();
      present(0, 1'b0, 32'h40, 32'h0, 4'hF);
      req_valid = 2'b01; PRDATA = 32'h13579BDF;
      sample();
      cyc_start();
      req_valid = 2'b00;
      repeat (30) cyc_start();
      sample();
      chk("nto_still_access", {PSEL, PENABLE}, 2'b11);
      chk("nto_norsp", rsp_valid, 0);
      cyc_start();
      PREADY = 1'b1;
      cyc_start();
      PREADY = 1'b0;
      sample();
      chk("nto_rsp", rsp_valid, 2'b01);
      chk("nto_err", rsp_err, 0);
      chk("nto_rdata", rsp_rdata, 32'h13579BDF);
`endif

      // ---------------- randomized traffic against a transaction-level model
      do_reset();
      for (int i = 0; i < 15; i++) begin
         t.w = 1'($urandom_range(1)); t.a = $urandom(); t.d = $urandom(); t.s = 4'($urandom_range(15));
         q0.push_back(t);
         t.w = 1'($urandom_range(1)); t.a = $urandom(); t.d = $urandom(); t.s = 4'($urandom_range(15));
         q1.push_back(t);
      end
      last_g = 1; active = 1'b0; acc_cyc = 0; rsp_at = -1; owner = 0;
      rsp_owner = 0; rsp_data = '0; rsp_e = 1'b0;
      for (int c = 0; c < 800; c++) begin
         vld = 2'b00;
         if (q0.size() > 0 && $urandom_range(3) != 0) begin
            vld[0] = 1'b1; present(0, q0[0].w, q0[0].a, q0[0].d, q0[0].s);
         end
         if (q1.size() > 0 && $urandom_range(3) != 0) begin
            vld[1] = 1'b1; present(1, q1[0].w, q1[0].a, q1[0].d, q1[0].s);
         end
         req_valid = vld;
         PREADY = ($urandom_range(2) != 0);
         PRDATA = $urandom();
         sample();

         eg = 2'b00;
         if (!active && vld != 2'b00) eg = (vld == 2'b11) ? oh(1 - last_g) : vld;
         exp_pen = active && (c >= acc_cyc + 2);
         chk("rnd_ready", req_ready, eg);
         chk("rnd_psel", PSEL, active);
         chk("rnd_penable", PENABLE, exp_pen);
         if (active) begin
            chk("rnd_paddr", PADDR, cur.a);
            chk("rnd_pwrite", PWRITE, cur.w);
            chk("rnd_pwdata", PWDATA, cur.d);
            chk("rnd_pstrb", PSTRB, cur.w ? cur.s : 4'h0);
         end
         if (rsp_at == c) begin
            chk("rnd_rsp_valid", rsp_valid, oh(rsp_owner));
            chk("rnd_rsp_rdata", rsp_rdata, rsp_data);
            chk("rnd_rsp_err", rsp_err, rsp_e);
         end else begin
            chk("rnd_rsp_idle", rsp_valid, 0);
         end

         if (active) begin
            if (exp_pen && PREADY) begin
               active = 1'b0; rsp_at = c + 1; rsp_owner = owner;
               rsp_data = cur.w ? 32'h0 : PRDATA; rsp_e = 1'b0;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (exp_pen && (c - (acc_cyc + 1)) == TO) begin
               active = 1'b0; rsp_at = c + 1; rsp_owner = owner;
               rsp_data = 32'h0; rsp_e = 1'b1;
            end
`endif
         end else if (eg != 2'b00) begin
            owner  = eg[1] ? 1 : 0;
            last_g = owner;
            cur    = (owner == 1) ? q1.pop_front() : q0.pop_front();
            active = 1'b1;
            acc_cyc = c;
         end
         cyc_start();
      end
      chk("rnd_q0_drained", q0.size(), 0);
      chk("rnd_q1_drained", q1.size(), 0);
      chk("rnd_idle_end", active, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width, a multiple of 8.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles, used only under the macro in REQ-027.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 PCLK  input  1  clock; all state changes on its rising edge.
REQ-006 PRESET  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  2  per-requester request valid; index 0 is requester 0.
REQ-008 req_ready  output  2  per-requester request accept.
REQ-009 req_write  input  2  per-requester direction; 1 = write.
REQ-010 req_addr  input  2*ADDR_W  per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-011 req_wdata  input  2*DATA_W  per-requester write data, sliced as REQ-010.
REQ-012 req_strb  input  2*DATA_W/8  per-requester byte strobes, sliced as REQ-010.
REQ-013 rsp_valid  output  2  one-cycle response pulse to the owning requester.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes.
REQ-015 rsp_err  output  1  response error flag.
REQ-016 PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-017 PADDR  output  ADDR_W;  PWDATA  output  DATA_W;  PSTRB  output  DATA_W/8: APB master payload.
REQ-018 PRDATA  input  DATA_W;  PREADY  input  1: APB slave response.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP and ACCESS; the transitions SHALL be IDLE->SETUP on an accepted request, SETUP->ACCESS unconditionally, and ACCESS->IDLE on PREADY=1.
REQ-020 In IDLE, req_ready SHALL be asserted combinationally for the granted requester only; all other states SHALL drive req_ready=2'b00.
REQ-021 Arbitration SHALL be round-robin: with one requester valid, that requester is granted; with both valid, the requester not granted last is granted; the last-granted pointer SHALL be 1 after reset, so requester 0 wins the first tie.
REQ-022 On a handshake (req_valid[i] & req_ready[i]) in cycle N, the block SHALL register the write flag, address, wdata and strobes of requester i and drive PSEL=1, PENABLE=0 in cycle N+1, then PSEL=1, PENABLE=1 from cycle N+2.
REQ-023 PADDR, PWRITE, PWDATA and PSTRB SHALL be held stable from SETUP through the last ACCESS cycle; PSTRB SHALL be 0 for reads.
REQ-024 Outside SETUP and ACCESS, PSEL and PENABLE SHALL be 0.
REQ-025 When PREADY=1 in ACCESS in cycle M, the block SHALL pulse rsp_valid[owner] in cycle M+1, with rsp_rdata=PRDATA sampled in cycle M for reads and 0 for writes, and rsp_err=0.
REQ-026 The block SHALL accept a new request in the same cycle that it pulses rsp_valid (IDLE); the minimum spacing between two transfers SHALL be 3 cycles.

Configuration
REQ-027 With APB_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; when TIMEOUT consecutive ACCESS cycles pass without PREADY, the block SHALL return to IDLE, deassert PSEL/PENABLE, and pulse rsp_valid[owner] next cycle with rsp_err=1 and rsp_rdata=0.
REQ-028 Under APB_ARB_TIMEOUT_EN, if PREADY=1 in the cycle the count reaches TIMEOUT, the block SHALL complete the transfer normally (rsp_err=0).
REQ-029 Without APB_ARB_TIMEOUT_EN, the block SHALL contain no counter, SHALL drive rsp_err constant 0, SHALL ignore TIMEOUT, and SHALL wait in ACCESS indefinitely.

Reset
REQ-030 When PRESET is asserted, the block SHALL asynchronously force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, last-granted pointer=1 and counter=0.
REQ-031 A reset asserted mid-transfer SHALL drop that transfer, and the block SHALL generate no response for it after release.

Structure
REQ-032 Package apb_arbiter_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS), the requester index typedef, and the default ADDR_W/DATA_W/TIMEOUT constants.
REQ-033 Round-robin grant logic SHALL live in sub-module apb_rr_arbiter (inputs: 2-bit valid and the pointer; output: one-hot grant).

Verification
REQ-034 Single write: req0 write, addr 0x10, wdata 0xDEADBEEF, strb 0xF, PREADY=1 in the first ACCESS -> SETUP at N+1, ACCESS at N+2, rsp_valid[0] at N+3, rsp_rdata=0.
REQ-035 Read with wait states: req1 read, addr 0x20, PREADY low for 3 ACCESS cycles then high with PRDATA=0x12345678 -> PADDR stable throughout, rsp_valid[1] with rsp_rdata=0x12345678.
REQ-036 Contention: both requesters valid continuously for 4 transfers -> grants in order 0,1,0,1, each new accept coinciding with the previous rsp_valid.
REQ-037 Reset mid-ACCESS: assert PRESET while PENABLE=1 -> PSEL=PENABLE=0 immediately, and no rsp_valid after release.
REQ-038 Timeout (macro on, TIMEOUT=4): PREADY held low -> exactly 4 ACCESS cycles, then rsp_err=1 and rsp_rdata=0; with PREADY=1 on the 4th ACCESS cycle -> rsp_err=0.
